mvm4_host_port: RTL and testbench



---
 rtl/mvm4_host_port.sv | 160 ++++++++++++++++
 tb/tb_mvm4_host_port.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm4_host_port.sv
// mvm4_host_port: host-side endpoint for the 4x4 matrix-vector engine.
// Holds one job (matrix + vector), streams it to the engine as 20 words,
// then captures the 4 results into a readable bank and reports a cycle count.
//
// Ports:
//   clk, reset        : single clock, synchronous active-high reset
//   ld_en/addr/data   : host write into the job buffer (IDLE only)
//   start             : begin a job (IDLE only)
//   busy, done        : not-IDLE flag, one-cycle completion pulse
//   tx_valid/ready/data : stream into the engine input port
//   rx_valid/ready/data : stream from the engine output port
//   rd_addr, rd_data  : combinational result read
//   cycles            : SEND+RECV cycle count of the last job (saturating)
module mvm4_host_port #(
    parameter int WIDTH  = 12,
    parameter int X_SIZE = 4,
    parameter int W_SIZE = 16,
    localparam int N_WORDS = W_SIZE + X_SIZE,
    localparam int LA = $clog2(N_WORDS),
    localparam int LR = $clog2(X_SIZE)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ld_en,
    input  logic [LA-1:0]               ld_addr,
    input  logic signed [WIDTH-1:0]     ld_data,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic signed [WIDTH-1:0]     tx_data,
    input  logic                        rx_valid,
    output logic                        rx_ready,
    input  logic signed [2*WIDTH-1:0]   rx_data,
    input  logic [LR-1:0]               rd_addr,
    output logic signed [2*WIDTH-1:0]   rd_data,
    output logic [15:0]                 cycles
);

    localparam logic [LA-1:0] LAST_TX = LA'(N_WORDS - 1);
    localparam logic [LR-1:0] LAST_RX = LR'(X_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        RECV,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [WIDTH-1:0]   job_mem [N_WORDS];
    logic signed [2*WIDTH-1:0] result  [X_SIZE];

    logic [LA-1:0] tx_idx;
    logic [LR-1:0] rx_idx;

    logic in_idle;
    logic in_send;
    logic in_recv;
    logic tx_fire;
    logic rx_fire;
    logic tx_last;
    logic rx_last;
    logic job_go;
    logic ld_ok;

    // Handshakes are decoded from state rather than from tx_valid/rx_ready
    // so the FSM comb block has no loop through its own outputs.
    assign in_idle = (state == IDLE);
    assign in_send = (state == SEND);
    assign in_recv = (state == RECV);
    assign tx_fire = in_send && tx_ready;
    assign rx_fire = in_recv && rx_valid;
    assign tx_last = (tx_idx == LAST_TX);
    assign rx_last = (rx_idx == LAST_RX);
    assign job_go  = in_idle && start;
    assign ld_ok   = in_idle && ld_en && (ld_addr <= LAST_TX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        tx_valid  = 1'b0;
        rx_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                tx_valid = 1'b1;
                if (tx_fire && tx_last) begin
                    state_nxt = RECV;
                end
            end
            RECV: begin
                rx_ready = 1'b1;
                if (rx_fire && rx_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Job buffer has no reset: a restart after reset re-sends the same job.
    // A write in the start cycle lands before the first word is read.
    always_ff @(posedge clk) begin
        if (ld_ok) begin
            job_mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || job_go) begin
            tx_idx <= '0;
            rx_idx <= '0;
            cycles <= '0;
            for (int i = 0; i < X_SIZE; i++) begin
                result[i] <= '0;
            end
        end else begin
            // tx_idx returns to 0 on the last word so it never
            // addresses past the end of the buffer.
            if (tx_fire) begin
                tx_idx <= tx_last ? '0 : tx_idx + LA'(1);
            end
            if (rx_fire) begin
                result[rx_idx] <= rx_data;
                rx_idx         <= rx_idx + LR'(1);
            end
            if ((in_send || in_recv) && (cycles != 16'hFFFF)) begin
                cycles <= cycles + 16'd1;
            end
        end
    end

    assign tx_data = in_send ? job_mem[tx_idx] : '0;
    assign rd_data = result[rd_addr];

endmodule

// File: tb/tb_mvm4_host_port.sv
// tb_mvm4_host_port: self-checking bench for mvm4_host_port.
// Directed vector table, hand sequences, and randomized jobs vs a job model.
module tb_mvm4_host_port;

    logic               clk = 1'b0;
    logic               reset;
    logic               ld_en;
    logic [4:0]         ld_addr;
    logic signed [11:0] ld_data;
    logic               start;
    logic               busy;
    logic               done;
    logic               tx_valid;
    logic               tx_ready;
    logic signed [11:0] tx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic signed [23:0] rx_data;
    logic [1:0]         rd_addr;
    logic signed [23:0] rd_data;
    logic [15:0]        cycles;

    mvm4_host_port dut (
        .clk      (clk),
        .reset    (reset),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .cycles   (cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        int               txm;
        int               rxm;
        bit               poke;
        bit               neg;
        int               cyc;
        logic [3:0][23:0] rv;
    } vec_t;

    vec_t tbl [5];

    // Model: job contents, engine replies, captured results, cycle count.
    logic signed [11:0] job [20];
    logic signed [23:0] rvq [4];
    logic signed [23:0] res [4];
    int                 mcyc;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm,
                       input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        else
            n_pass++;
    endtask

    function automatic vec_t mk(string n, int tx, int rx, bit pk,
                                bit ng, int cy, logic [95:0] rv);
        vec_t v;
        v.name = n;
        v.txm  = tx;
        v.rxm  = rx;
        v.poke = pk;
        v.neg  = ng;
        v.cyc  = cy;
        v.rv   = rv;
        return v;
    endfunction

    task automatic load_job();
        for (int i = 0; i < 20; i++) begin
            ld_en   = 1'b1;
            ld_addr = 5'(i);
            ld_data = job[i];
            @(posedge clk); #1;
        end
        ld_en = 1'b0;
    endtask

    // Called at posedge+1 in IDLE. Plays the engine: txm/rxm pick the
    // ready/valid pattern (0 = always, 1 = directed stall/gap, 2 = random).
    // ph: 0 idle, 1 sending, 2 receiving, 3 done.
    task automatic run_job(input int txm, input int rxm, input bit poke,
                           input bit ldstart, input logic signed [11:0] ldv);
        int ph, sent, got, stall, gap, n;
        start    = 1'b1;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        if (ldstart) begin
            ld_en   = 1'b1;
            ld_addr = 5'd19;
            ld_data = ldv;
            job[19] = ldv;
        end
        @(posedge clk); #1;
        start = 1'b0;
        ld_en = 1'b0;
        ph = 1; sent = 0; got = 0; stall = 0; gap = 2; n = 0; mcyc = 0;
        for (int k = 0; k < 4; k++) res[k] = '0;
        while (ph != 0 && n < 400) begin
            n++;
            tx_ready = 1'b1;
            if (txm == 1 && ph == 1 && sent == 5 && stall < 3) begin
                tx_ready = 1'b0;
                stall++;
            end
            if (txm == 2) tx_ready = ($urandom_range(0, 2) != 0);
            rx_valid = 1'b0;
            rx_data  = 24'($urandom);
            if (ph == 2) begin
                if (rxm == 0) rx_valid = 1'b1;
                else if (rxm == 1) rx_valid = (gap >= 2);
                else rx_valid = 1'($urandom_range(0, 1));
                if (rx_valid) rx_data = rvq[got];
            end else if (ph == 1) begin
                if (rxm == 1 && sent == 3) rx_valid = 1'b1;
                if (rxm == 2) rx_valid = 1'($urandom_range(0, 1));
            end
            if (poke && ph == 1 && sent == 7) begin
                ld_en   = 1'b1;
                ld_addr = 5'd3;
                ld_data = 12'sd999;
            end
            if (poke && ph == 2 && got == 1) start = 1'b1;
            rd_addr = (ph == 1 && sent == 4) ? 2'd0 : 2'($urandom_range(0, 3));
            #4;
            chk("tx_valid", tx_valid, ph == 1);
            chk("rx_ready", rx_ready, ph == 2);
            chk("busy", busy, ph != 0);
            chk("done", done, ph == 3);
            if (ph == 1) chk("tx_data", tx_data, job[sent]);
            chk("rd_data", rd_data, res[rd_addr]);
            case (ph)
                1: begin
                    mcyc++;
                    if (tx_ready) begin
                        sent++;
                        if (sent == 20) ph = 2;
                    end
                end
                2: begin
                    mcyc++;
                    if (rx_valid) begin
                        res[got] = rx_data;
                        got++;
                        gap = 0;
                        if (got == 4) ph = 3;
                    end else begin
                        gap++;
                    end
                end
                default: ph = 0;
            endcase
            @(posedge clk); #1;
            ld_en = 1'b0;
            start = 1'b0;
        end
        if (n >= 400) chk("job_timeout", ph, 0);
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        #4;
        chk("idle_busy", busy, 0);
        chk("cycles_model", cycles, mcyc);
    endtask

    initial begin
        reset    = 1'b1;
        ld_en    = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        start    = 1'b0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        rd_addr  = '0;

        tbl[0] = mk("basic", 0, 0, 0, 0, 24,
                    {24'd400, 24'd300, 24'd200, 24'd100});
        tbl[1] = mk("tx_stall", 1, 0, 0, 0, 27,
                    {24'd8, 24'd7, 24'd6, 24'd5});
        tbl[2] = mk("rx_gaps", 0, 1, 0, 0, 30,
                    {24'd44, 24'd33, 24'd22, 24'd11});
        tbl[3] = mk("negative", 0, 0, 0, 1, 24,
                    {24'hFFFFFF, 24'h800000, 24'h7FFFFF, 24'hFFFFFF});
        tbl[4] = mk("ignored", 0, 0, 1, 0, 24,
                    {24'd4, 24'd3, 24'd2, 24'd1});

        repeat (3) @(posedge clk);
        #1; #4;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_cycles", cycles, 0);
        chk("rst_result", rd_data, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 20; i++) job[i] = 12'(i + 1);
            if (tbl[t].neg) begin
                job[0] = 12'h800;
                job[1] = 12'h7FF;
                job[7] = 12'hFFF;
            end
            load_job();
            if (tbl[t].poke) begin
                ld_en   = 1'b1;
                ld_addr = 5'd25;
                ld_data = 12'sd77;
                @(posedge clk); #1;
                ld_en = 1'b0;
            end
            for (int k = 0; k < 4; k++) rvq[k] = tbl[t].rv[k];
            run_job(tbl[t].txm, tbl[t].rxm, tbl[t].poke, 1'b0, '0);
            chk({tbl[t].name, "_cycles"}, cycles, tbl[t].cyc);
            for (int k = 0; k < 4; k++) begin
                rd_addr = 2'(k);
                #1;
                chk({tbl[t].name, "_result"}, rd_data,
                    $signed(tbl[t].rv[k]));
            end
            @(posedge clk); #1;
        end

        // Re-run without reloading: buffer must be untouched by the
        // ignored writes above and by the dropped address-25 write.
        for (int k = 0; k < 4; k++) rvq[k] = 24'(k * 1000 + 7);
        run_job(0, 0, 1'b0, 1'b0, '0);
        @(posedge clk); #1;

        // Abort after 10 words, then restart from buf[0].
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        tx_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #4;
            chk("pre_reset_tx", tx_data, job[k]);
            @(posedge clk); #1;
        end
        reset   = 1'b1;
        rd_addr = 2'd0;
        @(posedge clk); #1; #4;
        chk("abort_busy", busy, 0);
        chk("abort_tx_valid", tx_valid, 0);
        chk("abort_cycles", cycles, 0);
        chk("abort_result", rd_data, 0);
        reset    = 1'b0;
        tx_ready = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) rvq[k] = -24'(k + 1);
        run_job(0, 0, 1'b0, 1'b0, '0);
        chk("restart_cycles", cycles, 24);
        @(posedge clk); #1;

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 20; i++) job[i] = 12'($urandom);
            load_job();
            for (int k = 0; k < 4; k++) rvq[k] = 24'($urandom);
            run_job(2, 2, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 12'($urandom));
            for (int k = 0; k < 4; k++) begin
                rd_addr = 2'(k);
                #1;
                chk("rand_result", rd_data, rvq[k]);
            end
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
